load_fifo33: RTL

LOAD_FIFO33 -- requirements
Module: load_fifo33

---
 rtl/load_fifo33.sv | 90 +++++++++
 1 files changed

// File: rtl/load_fifo33.sv
// load_fifo33 -- first-word-fall-through FIFO fed by a 33-bit packed word.
//
// The upstream packer drives data_in = {payload[31:0], load}. Every rising
// edge with load=1 requests a push of the payload. The head entry is shown
// combinationally on data_out while the FIFO is non-empty, and is forced to
// zero while empty so stale storage never leaks out.
//
// Ports
//   CLK      in   system clock, all state on the rising edge
//   RESETn   in   asynchronous active-low reset
//   data_in  in   [32:1] payload, [0] push strobe (level, one push per cycle)
//   RE       in   pop the head entry (ignored while empty)
//   CLR_OVF  in   clear the sticky overflow flag (a same-edge overflow wins)
//   data_out out  head payload, 0 while EMPTY
//   EMPTY    out  occupancy == 0
//   FULL     out  occupancy == DEPTH
//   COUNT    out  occupancy, 0..DEPTH
//   OVF      out  sticky: a push was dropped because the FIFO was full
module load_fifo33 #(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RESETn,
   input  logic [32:0]                data_in,
   input  logic                       RE,
   input  logic                       CLR_OVF,
   output logic [31:0]                data_out,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic [$clog2(DEPTH):0]     COUNT,
   output logic                       OVF
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] payload;
      logic        load;
   } push_req_t;

   push_req_t        req;
   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             ovf;
   logic             pop, push, drop;

   assign req = push_req_t'(data_in);

   assign EMPTY = (count == '0);
   assign FULL  = (count == DEPTH_C);
   assign COUNT = count;
   assign OVF   = ovf;

   // A pop frees a slot in the same edge, so a full FIFO still accepts a
   // push when it is also being read. There is no empty bypass: a push into
   // an empty FIFO only becomes visible one edge later.
   assign pop  = RE && !EMPTY;
   assign push = req.load && (!FULL || pop);
   assign drop = req.load && FULL && !pop;

   // Pointers are AW bits wide and DEPTH is a power of two, so natural
   // overflow of the adders gives the modulo-DEPTH wrap.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         // Set has priority over clear.
         if (drop)         ovf <= 1'b1;
         else if (CLR_OVF) ovf <= 1'b0;
      end
   end

   // Storage is deliberately not reset; it is masked by EMPTY on the output.
   always_ff @(posedge CLK) begin
      if (push && RESETn) mem[wr_ptr] <= req.payload;
   end

   assign data_out = EMPTY ? 32'd0 : mem[rd_ptr];

endmodule
